// File: rtl/pipe_out_gen_pkg.sv
// Shared definitions for the pipe_out_gen pattern source: generator modes,
// LFSR feedback taps and the substitute seed used when the supplied seed is zero.
package pipe_out_gen_pkg;

    typedef enum logic [2:0] {
        PAT_COUNT = 3'd0,
        PAT_LFSR  = 3'd1,
        PAT_WALK1 = 3'd2,
        PAT_WALK0 = 3'd3,
        PAT_ALT   = 3'd4
    } pat_mode_e;

    // Feedback taps 64,63,61,60 expressed as a mask over bits [63:0]
    localparam logic [63:0] LFSR_TAPS    = 64'hD800_0000_0000_0000;
    localparam logic [63:0] DEFAULT_SEED = 64'h0000_0000_0000_0001;

    function automatic logic [63:0] lfsr_next(input logic [63:0] s);
        return {s[62:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/pog_pattern.sv
// Word generator for pipe_out_gen. Every mode's state advances on each enabled
// cycle, so switching mode mid-stream continues from the shared read position.
module pog_pattern
    import pipe_out_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            mode,
    input  logic [63:0]           seed,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic [63:0]           lfsr_q, lfsr_d;
    logic [DATA_WIDTH-1:0] walk_q, walk_d;
    logic                  alt_q, alt_d;
    logic [DATA_WIDTH-1:0] alt_word;

    // 0xAA.. pattern: odd bit positions set
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_alt
        assign alt_word[gi] = (gi % 2) == 1;
    end

    always_comb begin
        cnt_d  = cnt_q;
        lfsr_d = lfsr_q;
        walk_d = walk_q;
        alt_d  = alt_q;
        if (enable) begin
            cnt_d  = cnt_q + 1'b1;
            lfsr_d = lfsr_next(lfsr_q);
            walk_d = {walk_q[DATA_WIDTH-2:0], walk_q[DATA_WIDTH-1]};
            alt_d  = ~alt_q;
        end
    end

    always_comb begin
        dout = '0;
        case (mode)
            PAT_COUNT: dout = cnt_q;
            PAT_LFSR:  dout = lfsr_q[DATA_WIDTH-1:0];
            PAT_WALK1: dout = walk_q;
            PAT_WALK0: dout = ~walk_q;
            PAT_ALT:   dout = alt_q ? ~alt_word : alt_word;
            default:   dout = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            lfsr_q <= (seed == 64'h0) ? DEFAULT_SEED : seed;
            walk_q <= DATA_WIDTH'(1);
            alt_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lfsr_q <= lfsr_d;
            walk_q <= walk_d;
            alt_q  <= alt_d;
        end
    end

endmodule

// File: rtl/pipe_out_gen.sv
// Throttled virtual-FIFO pattern source for Pipe Out testing.
// Optional single-word bit-0 error injection is built when PIPE_OUT_GEN_ERRINJ_EN is defined.
module pipe_out_gen
    import pipe_out_gen_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int LEVEL_WIDTH    = 16,
    parameter int THROTTLE_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pipe_out_read,
    output logic [DATA_WIDTH-1:0]     pipe_out_data,
    output logic                      pipe_out_ready,
    input  logic                      throttle_set,
    input  logic [THROTTLE_WIDTH-1:0] throttle_val,
    input  logic [LEVEL_WIDTH-1:0]    block_size,
    input  logic [2:0]                pattern,
    input  logic [63:0]               seed,
    input  logic                      clear_err,
    input  logic                      inject_err,
    output logic [LEVEL_WIDTH-1:0]    level,
    output logic                      underflow,
    output logic [31:0]               words_read
);

    logic [THROTTLE_WIDTH-1:0] thr_q, thr_d;
    logic [LEVEL_WIDTH-1:0]    level_q, level_d;
    logic                      ready_q, ready_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      under_q, under_d;
    logic [31:0]               words_q, words_d;
    logic [DATA_WIDTH-1:0]     gen_word;
    logic                      flip;

    pog_pattern #(.DATA_WIDTH(DATA_WIDTH)) u_pattern (
        .clk    (clk),
        .reset  (reset),
        .mode   (pattern),
        .seed   (seed),
        .enable (pipe_out_read),
        .dout   (gen_word)
    );

`ifdef PIPE_OUT_GEN_ERRINJ_EN
    logic armed_q, armed_d;

    // A request in the same cycle as a read corrupts that read
    assign flip    = armed_q | inject_err;
    assign armed_d = pipe_out_read ? 1'b0 : flip;

    always_ff @(posedge clk) begin
        if (reset) armed_q <= 1'b0;
        else       armed_q <= armed_d;
    end
`else
    logic unused_inject_err;
    assign unused_inject_err = inject_err;
    assign flip = 1'b0;
`endif

    always_comb begin
        thr_d   = throttle_set ? throttle_val : {thr_q[0], thr_q[THROTTLE_WIDTH-1:1]};
        level_d = level_q;
        ready_d = (level_q >= block_size);
        data_d  = data_q;
        under_d = under_q;
        words_d = words_q;

        // The pre-update throttle bit is the write enable, even on a reload cycle
        case ({pipe_out_read, thr_q[0]})
            2'b01:   if (level_q != '1) level_d = level_q + 1'b1;
            2'b10:   if (level_q != '0) level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (pipe_out_read) begin
            data_d  = gen_word ^ DATA_WIDTH'(flip);
            words_d = words_q + 1'b1;
        end

        if (pipe_out_read && (level_q == '0)) under_d = 1'b1;
        else if (clear_err)                   under_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            thr_q   <= throttle_val;
            level_q <= '0;
            ready_q <= 1'b0;
            data_q  <= '0;
            under_q <= 1'b0;
            words_q <= '0;
        end else begin
            thr_q   <= thr_d;
            level_q <= level_d;
            ready_q <= ready_d;
            data_q  <= data_d;
            under_q <= under_d;
            words_q <= words_d;
        end
    end

    assign pipe_out_data  = data_q;
    assign pipe_out_ready = ready_q;
    assign level          = level_q;
    assign underflow      = under_q;
    assign words_read     = words_q;

endmodule

// File: tb/tb_pipe_out_gen.sv
// Directed bench for pipe_out_gen: a read-count based reference model checked every
// cycle, plus literal expectations for the key sequences.
module tb_pipe_out_gen;

    localparam int DW   = 32;
    localparam int LW   = 12;
    localparam int TW   = 32;
    localparam int MAXL = (1 << LW) - 1;

    logic          clk;
    logic          reset;
    logic          pipe_out_read;
    logic [DW-1:0] pipe_out_data;
    logic          pipe_out_ready;
    logic          throttle_set;
    logic [TW-1:0] throttle_val;
    logic [LW-1:0] block_size;
    logic [2:0]    pattern;
    logic [63:0]   seed;
    logic          clear_err;
    logic          inject_err;
    logic [LW-1:0] level;
    logic          underflow;
    logic [31:0]   words_read;

    int checks   = 0;
    int failures = 0;

    pipe_out_gen #(.DATA_WIDTH(DW), .LEVEL_WIDTH(LW), .THROTTLE_WIDTH(TW)) dut (
        .clk            (clk),
        .reset          (reset),
        .pipe_out_read  (pipe_out_read),
        .pipe_out_data  (pipe_out_data),
        .pipe_out_ready (pipe_out_ready),
        .throttle_set   (throttle_set),
        .throttle_val   (throttle_val),
        .block_size     (block_size),
        .pattern        (pattern),
        .seed           (seed),
        .clear_err      (clear_err),
        .inject_err     (inject_err),
        .level          (level),
        .underflow      (underflow),
        .words_read     (words_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [TW-1:0] m_thr;
    int            m_level;
    bit            m_ready;
    bit            m_under;
    logic [31:0]   m_words;
    logic [DW-1:0] m_data;
    logic [63:0]   m_lfsr;
    int            m_k;
    bit            m_armed;
    bit            m_valid = 1'b0;

    function automatic logic [63:0] ref_lfsr_step(input logic [63:0] s);
        int taps [4] = '{64, 63, 61, 60};
        bit fb = 1'b0;
        foreach (taps[i]) fb ^= s[taps[i]-1];
        return {s[62:0], fb};
    endfunction

    function automatic logic [DW-1:0] ref_word(input int mode, input int k, input logic [63:0] lf);
        logic [DW-1:0] one = 1;
        logic [DW-1:0] aa;
        for (int i = 0; i < DW; i++) aa[i] = i[0];
        case (mode)
            0:       return DW'(k);
            1:       return lf[DW-1:0];
            2:       return one << (k % DW);
            3:       return ~(one << (k % DW));
            4:       return (k % 2 == 0) ? aa : ~aa;
            default: return '0;
        endcase
    endfunction

    initial forever begin : model
        bit we;
        bit flip;
        @(posedge clk);
        if (reset) begin
            m_thr   = throttle_val;
            m_level = 0;
            m_ready = 0;
            m_under = 0;
            m_words = 0;
            m_data  = 0;
            m_k     = 0;
            m_lfsr  = (seed == 64'h0) ? 64'h1 : seed;
            m_armed = 0;
            m_valid = 1'b1;
        end else begin
            we      = m_thr[0];
            m_ready = (m_level >= int'(block_size));
            flip    = 1'b0;
`ifdef PIPE_OUT_GEN_ERRINJ_EN
            flip    = m_armed | inject_err;
            m_armed = pipe_out_read ? 1'b0 : (m_armed | inject_err);
`endif
            if (pipe_out_read && m_level == 0) m_under = 1;
            else if (clear_err)                m_under = 0;
            if (pipe_out_read) begin
                m_data  = ref_word(int'(pattern), m_k, m_lfsr) ^ DW'(flip);
                m_k++;
                m_lfsr  = ref_lfsr_step(m_lfsr);
                m_words = m_words + 1;
            end
            if (we && !pipe_out_read && m_level < MAXL)      m_level++;
            else if (!we && pipe_out_read && m_level > 0)   m_level--;
            m_thr = throttle_set ? throttle_val : {m_thr[0], m_thr[TW-1:1]};
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("cyc_data",  64'(pipe_out_data),  64'(m_data));
            chk("cyc_ready", 64'(pipe_out_ready), 64'(m_ready));
            chk("cyc_level", 64'(level),          64'(m_level));
            chk("cyc_under", 64'(underflow),      64'(m_under));
            chk("cyc_words", 64'(words_read),     64'(m_words));
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_read();
        pipe_out_read = 1'b1;
        @(posedge clk);
        #1 pipe_out_read = 1'b0;
        $display("read pattern=%0d data=%h level=%0d underflow=%0b words=%0d",
                 pattern, pipe_out_data, level, underflow, words_read);
    endtask

    initial begin
        reset = 1'b1; pipe_out_read = 1'b0; throttle_set = 1'b0;
        throttle_val = 32'hFFFF_FFFF; block_size = LW'(1024); pattern = 3'd0;
        seed = 64'h1; clear_err = 1'b0; inject_err = 1'b0;

        // Fill with full throttle, ready threshold and saturation
        do_reset();
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_ready", 64'(pipe_out_ready), 64'd0);
        chk("rst_data",  64'(pipe_out_data), 64'd0);
        chk("rst_under", 64'(underflow), 64'd0);
        chk("rst_words", 64'(words_read), 64'd0);
        idle(1024);
        chk("fill_level_1024", 64'(level), 64'd1024);
        chk("fill_ready_lag",  64'(pipe_out_ready), 64'd0);
        idle(1);
        chk("fill_ready_rise", 64'(pipe_out_ready), 64'd1);
        idle(3200);
        chk("fill_saturate", 64'(level), 64'(MAXL));

        // Stop filling, then four count reads
        throttle_set = 1'b1; throttle_val = 32'h0;
        idle(1);
        throttle_set = 1'b0;
        chk("reload_level", 64'(level), 64'(MAXL));
        for (int i = 0; i < 4; i++) begin
            do_read();
            chk("count_data", 64'(pipe_out_data), 64'(i));
        end
        chk("count_level", 64'(level), 64'(MAXL - 4));
        chk("count_words", 64'(words_read), 64'd4);

        // LFSR: seed 1 and seed 0 give the same stream
        pattern = 3'd1; throttle_val = 32'hFFFF_FFFF;
        for (int s = 0; s < 2; s++) begin
            seed = (s == 0) ? 64'h1 : 64'h0;
            do_reset();
            for (int i = 0; i < 8; i++) begin
                do_read();
                chk("lfsr_data", 64'(pipe_out_data), 64'(32'h1 << i));
            end
        end

        // Mode changes continue from the shared read position (k = 8..13)
        pattern = 3'd2; do_read(); chk("walk1_k8", 64'(pipe_out_data), 64'h0000_0100);
        pattern = 3'd3; do_read(); chk("walk0_k9", 64'(pipe_out_data), 64'hFFFF_FDFF);
        pattern = 3'd4; do_read(); chk("alt_k10",  64'(pipe_out_data), 64'hAAAA_AAAA);
        do_read();                 chk("alt_k11",  64'(pipe_out_data), 64'h5555_5555);
        pattern = 3'd5; do_read(); chk("const_k12", 64'(pipe_out_data), 64'h0);
        pattern = 3'd0; do_read(); chk("count_k13", 64'(pipe_out_data), 64'hD);

        // LFSR with feedback active early; checked by the model
        pattern = 3'd1; seed = 64'hF000_0000_0000_0000;
        do_reset();
        do_read(); chk("lfsr_hi_seed_first", 64'(pipe_out_data), 64'h0);
        for (int i = 0; i < 70; i++) do_read();

        // Sparse throttle: one write per 32 cycles, block_size 0
        throttle_val = 32'h1; block_size = '0; pattern = 3'd0;
        do_reset();
        idle(96);
        chk("sparse_level_96", 64'(level), 64'd3);
        chk("sparse_ready",    64'(pipe_out_ready), 64'd1);
        idle(1);
        chk("sparse_level_97", 64'(level), 64'd4);

        // Underflow set/clear priority
        throttle_val = 32'h0;
        do_reset();
        do_read();
        chk("uf_set",   64'(underflow), 64'd1);
        chk("uf_level", 64'(level), 64'd0);
        chk("uf_data",  64'(pipe_out_data), 64'd0);
        clear_err = 1'b1; idle(1); clear_err = 1'b0;
        chk("uf_clear", 64'(underflow), 64'd0);
        do_read();
        clear_err = 1'b1; do_read(); clear_err = 1'b0;
        chk("uf_set_wins", 64'(underflow), 64'd1);
        clear_err = 1'b1; idle(1); clear_err = 1'b0;
        chk("uf_clear2", 64'(underflow), 64'd0);

        // Error injection: one request, then two collapsed requests
        do_reset();
        inject_err = 1'b1; idle(1); inject_err = 1'b0; idle(1);
`ifdef PIPE_OUT_GEN_ERRINJ_EN
        do_read(); chk("inj_w0", 64'(pipe_out_data), 64'd1);
`else
        do_read(); chk("inj_w0", 64'(pipe_out_data), 64'd0);
`endif
        do_read(); chk("inj_w1", 64'(pipe_out_data), 64'd1);
        do_read(); chk("inj_w2", 64'(pipe_out_data), 64'd2);
        inject_err = 1'b1; idle(2); inject_err = 1'b0;
`ifdef PIPE_OUT_GEN_ERRINJ_EN
        do_read(); chk("inj_w3", 64'(pipe_out_data), 64'd2);
`else
        do_read(); chk("inj_w3", 64'(pipe_out_data), 64'd3);
`endif
        do_read(); chk("inj_w4", 64'(pipe_out_data), 64'd4);

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        failures++;
        $display("FAIL watchdog t=%0t got=timeout expected=completion", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_out_gen.md
# pipe_out_gen

Parametrised pseudorandom/pattern source for Pipe Out and block-throttled Pipe Out verification. It models a virtual FIFO whose fill rate comes from a circular throttle register and whose drain is host reads. It asserts ready once a programmable block's worth of words is available, and reports underflow and read counts. It sits between the host-interface pipe endpoint and the test register bank in the PipeTest design.

## Interface
- DATA_WIDTH, 32: output word width, 8..64
- LEVEL_WIDTH, 16: virtual FIFO level counter width
- THROTTLE_WIDTH, 32: circular throttle register width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- pipe_out_read  in  1  host consumes one word this cycle
- pipe_out_data  out  DATA_WIDTH  word presented to host
- pipe_out_ready  out  1  at least block_size words available
- throttle_set  in  1  reload throttle from throttle_val
- throttle_val  in  THROTTLE_WIDTH  throttle pattern
- block_size  in  LEVEL_WIDTH  ready threshold in words; 0 means always ready
- pattern  in  3  generator mode
- seed  in  64  LFSR seed, sampled at reset
- clear_err  in  1  clears underflow flag
- inject_err  in  1  single-word error injection request (see Configuration)
- level  out  LEVEL_WIDTH  current virtual FIFO level
- underflow  out  1  sticky: read occurred while level==0
- words_read  out  32  reads since reset, wraps at 2^32

## Operation
- Patterns: 0 count (starts at 0, +1 per read, modulo 2^DATA_WIDTH). 1 LFSR, 64-bit Fibonacci, taps 64,63,61,60, loaded with seed (seed==0 replaced by 64'h1), output = low DATA_WIDTH bits. 2 walking one (starts 1, rotate left per read). 3 walking zero (starts ~1, rotate left). 4 alternating (starts 0xAA.., inverts per read). 5–7 constant 0.
- The generator advances only on pipe_out_read. A pattern change takes effect on the next read without re-seeding. Only reset restarts the sequence.
- Throttle: rotates right every non-reset cycle; bit 0 is the write-enable for the cycle. With throttle_set high, it loads throttle_val instead of rotating, and bit 0 of the old value still applies that cycle.
- Level update on {pipe_out_read, throttle[0]}:
  - 00: hold
  - 01: +1, saturating at 2^LEVEL_WIDTH-1
  - 10: −1, saturating at 0
  - 11: hold
- Underflow: pipe_out_read with level==0 sets underflow. clear_err clears it. Simultaneous set and clear: set wins.
- Reads are never blocked. Data is always produced; underflow only flags.

## Timing
- Reset values:
  - pipe_out_data 0
  - pipe_out_ready 0
  - level 0
  - underflow 0
  - words_read 0
  - throttle = throttle_val
  - generator at initial value
- Data latency 1: read in cycle N loads the generator's current word into pipe_out_data at edge N+1, and the generator steps at the same edge. With no read, pipe_out_data holds.
- Ready latency 1: pipe_out_ready at edge N+1 = (level_N >= block_size). A level change is therefore reflected in ready 2 cycles after the causing event.
- Reset mid-operation: all state returns to reset values at the next edge, and the sequence restarts from the initial value.

## Configuration
- PIPE_OUT_GEN_ERRINJ_EN defined: inject_err arms a one-shot. The next read's output word has bit 0 inverted. The generator sequence is unaffected, so following words are correct. Multiple requests before the read collapse to one. Reset disarms.
- Not defined: inject_err is ignored and no arming register exists. Output is always the clean sequence.

## Structure
- Package pipe_out_gen_pkg: pattern mode enum (PAT_COUNT, PAT_LFSR, PAT_WALK1, PAT_WALK0, PAT_ALT), LFSR tap constant, default nonzero seed.
- Sub-module pog_pattern: generator (mode, seed, enable → dout), parametrised by DATA_WIDTH. Level/throttle/ready logic stays in the top.

## Test plan
- throttle_val=32'hFFFFFFFF, block_size=1024, no reads → level reaches 1024 after 1024 cycles; ready rises one cycle later; level saturates at 65535.
- throttle_val=32'h1, no reads → level increments once per 32 cycles; level=3 after 96 cycles.
- pattern=0, level 1024, 4 consecutive reads → data 0,1,2,3 on the edges after each read; level −4; words_read=4.
- pattern=1, seed=64'h1 vs seed=0 → identical streams; first 8 words match the reference model.
- throttle_val=0, read at level 0 → underflow=1, level stays 0; clear_err in the same cycle as a second underflowing read → underflow stays 1.
- With PIPE_OUT_GEN_ERRINJ_EN, pattern=0: inject_err then reads → words 0,1,2 arrive as 1,1,2. Without the macro → 0,1,2.
